fetch: RTL and testbench

FETCH -- requirements
Module: fetch

---
 rtl/riscv_defines.sv | 13 +
 rtl/fetch.sv | 145 ++++++++++++++
 tb/tb_fetch.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_defines.sv
// Shared RISC-V front-end definitions: fetch FSM states and the bubble encoding.
package riscv_defines;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    // addi x0,x0,0
    localparam logic [31:0] NOP_ENCODING = 32'h0000_0013;

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding imem request, one-entry response buffer, IF/ID register.
// Optional FETCH_MISALIGN_CHECK_EN: misaligned redirects raise fetch_fault_o and halt requests.
module fetch
    import riscv_defines::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = NOP_ENCODING
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        instr_valid_o,
    output logic        fetch_fault_o
);

    fetch_state_t state_q;
    logic [31:0]  fetch_pc_q;
    logic [31:0]  req_pc_q;
    logic         kill_q;
    logic [31:0]  buf_instr_q;
    logic [31:0]  buf_pc_q;
    logic [31:0]  instr_q, instr_d;
    logic [31:0]  pc_q, pc_d;
    logic         valid_q, valid_d;
    logic         fault_q;

    logic         redirect_ok;
    logic [31:0]  redirect_target;
    logic         granted;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign redirect_ok     = (redirect_pc_i[1:0] == 2'b00);
    assign redirect_target = redirect_pc_i;
`else
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc_i[1:0];
    assign redirect_ok          = 1'b1;
    assign redirect_target      = {redirect_pc_i[31:2], 2'b00};
`endif

    assign imem_req_o    = (state_q == S_REQ) && !fault_q;
    assign imem_addr_o   = fetch_pc_q;
    assign granted       = imem_req_o && imem_gnt_i;

    assign instr_o       = instr_q;
    assign pc_o          = pc_q;
    assign instr_valid_o = valid_q;
    assign fetch_fault_o = fault_q;

    // A redirect in the same cycle as a response also kills it, since that word is from the old stream.
    always_comb begin
        instr_d = instr_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (flush_i) begin
            instr_d = NOP_INSTR;
            pc_d    = 32'h0;
            valid_d = 1'b0;
        end else if (!stall_i) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            if (state_q == S_WAIT && imem_rvalid_i && !kill_q && !redirect_i) begin
                instr_d = imem_rdata_i;
                pc_d    = req_pc_q;
                valid_d = 1'b1;
            end else if (state_q == S_HOLD && !redirect_i) begin
                instr_d = buf_instr_q;
                pc_d    = buf_pc_q;
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= 32'h0;
            kill_q      <= 1'b0;
            buf_instr_q <= 32'h0;
            buf_pc_q    <= 32'h0;
            instr_q     <= NOP_INSTR;
            pc_q        <= 32'h0;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;

            case (state_q)
                S_REQ: begin
                    if (granted) begin
                        req_pc_q <= fetch_pc_q;
                        kill_q   <= redirect_i;
                        state_q  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        kill_q <= 1'b0;
                        if (kill_q || redirect_i || !stall_i) begin
                            state_q <= S_REQ;
                        end else begin
                            buf_instr_q <= imem_rdata_i;
                            buf_pc_q    <= req_pc_q;
                            state_q     <= S_HOLD;
                        end
                    end else if (redirect_i) begin
                        kill_q <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (redirect_i || !stall_i) begin
                        state_q <= S_REQ;
                    end
                end
                default: state_q <= S_REQ;
            endcase

            // A rejected (misaligned) redirect keeps the old fetch_pc and latches the fault.
            if (redirect_i) begin
                if (redirect_ok) begin
                    fetch_pc_q <= redirect_target;
                    fault_q    <= 1'b0;
                end else begin
                    fault_q    <= 1'b1;
                end
            end else if (granted) begin
                fetch_pc_q <= fetch_pc_q + 32'd4;
            end
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Self-checking bench for fetch: directed scenarios plus randomized traffic against a transaction-level model.
module tb_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        redirect;
    logic [31:0] redirectPc;
    logic        stall;
    logic        flush;
    logic [31:0] instrOut;
    logic [31:0] pcOut;
    logic        validOut;
    logic        faultOut;

    int checks = 0;
    int errors = 0;

    // Model of the fetch stage as transactions: one word in flight, one word parked.
    bit          mOut;
    bit          mKilled;
    logic [31:0] mReqPc;
    bit          mHeld;
    logic [31:0] mHeldPc;
    logic [31:0] mAddr;
    bit          mFault;
    logic [31:0] mInstr;
    logic [31:0] mPc;
    bit          mValid;
    int          respCnt;
    bit          strayRvalid;

    fetch #(
        .RESET_PC (RESET_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .imem_req_o   (imemReq),
        .imem_addr_o  (imemAddr),
        .imem_gnt_i   (gnt),
        .imem_rvalid_i(rvalid),
        .imem_rdata_i (rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(redirectPc),
        .stall_i      (stall),
        .flush_i      (flush),
        .instr_o      (instrOut),
        .pc_o         (pcOut),
        .instr_valid_o(validOut),
        .fetch_fault_o(faultOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        if (a == 32'h4) return 32'h00A0_0113;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
    endfunction

    task automatic modelReset();
        mOut    = 0;
        mKilled = 0;
        mReqPc  = 32'h0;
        mHeld   = 0;
        mHeldPc = 32'h0;
        mAddr   = RESET_PC;
        mFault  = 0;
        mInstr  = NOP;
        mPc     = 32'h0;
        mValid  = 0;
        respCnt = 0;
    endtask

    task automatic idleInputs();
        gnt         = 0;
        redirect    = 0;
        redirectPc  = 32'h0;
        stall       = 0;
        flush       = 0;
        strayRvalid = 0;
    endtask

    // One clock cycle: drive the memory response, predict, clock, compare.
    task automatic step(input int lat);
        bit          expReq;
        bit          granted;
        bit          deliver;
        bit          rOk;
        logic [31:0] dPc;
        logic [31:0] target;
        deliver = 0;
        dPc     = 32'h0;
        rvalid  = strayRvalid || (mOut && respCnt == 1);
        rdata   = rvalid ? memWord(mOut ? mReqPc : 32'hC0DE_0000) : 32'hDEAD_BEEF;
        expReq  = !mOut && !mHeld && !mFault;
        #1;
        checks++;
        if (imemReq !== expReq) begin
            errors++;
            $display("[TB] FAIL req: actual=%0b required=%0b at %0t", imemReq, expReq, $time);
        end
        if (expReq) begin
            checks++;
            if (imemAddr !== mAddr) begin
                errors++;
                $display("[TB] FAIL addr: actual=%h required=%h at %0t", imemAddr, mAddr, $time);
            end
        end
`ifdef FETCH_MISALIGN_CHECK_EN
        rOk    = (redirectPc[1:0] == 2'b00);
        target = redirectPc;
`else
        rOk    = 1;
        target = redirectPc & 32'hFFFF_FFFC;
`endif
        if (mOut && rvalid) begin
            mOut = 0;
            if (!(mKilled || redirect)) begin
                if (stall) begin
                    mHeld   = 1;
                    mHeldPc = mReqPc;
                end else begin
                    deliver = 1;
                    dPc     = mReqPc;
                end
            end
        end else if (mHeld && !redirect && !stall) begin
            deliver = 1;
            dPc     = mHeldPc;
            mHeld   = 0;
        end
        if (redirect) begin
            mHeld = 0;
            if (mOut) mKilled = 1;
        end
        granted = expReq && gnt;
        if (granted) begin
            mOut    = 1;
            mKilled = redirect;
            mReqPc  = mAddr;
            if (!redirect) mAddr = mAddr + 32'd4;
        end
        if (redirect) begin
            if (rOk) begin
                mAddr  = target;
                mFault = 0;
            end else begin
                mFault = 1;
            end
        end
        if (flush) begin
            mInstr = NOP;
            mPc    = 32'h0;
            mValid = 0;
        end else if (!stall) begin
            if (deliver) begin
                mInstr = memWord(dPc);
                mPc    = dPc;
                mValid = 1;
            end else begin
                mInstr = NOP;
                mValid = 0;
            end
        end
        @(posedge clk);
        #1;
        if (granted) respCnt = lat;
        else if (respCnt > 0) respCnt--;
        checks += 4;
        if (instrOut !== mInstr) begin
            errors++;
            $display("[TB] FAIL instr: actual=%h required=%h at %0t", instrOut, mInstr, $time);
        end
        if (pcOut !== mPc) begin
            errors++;
            $display("[TB] FAIL pc: actual=%h required=%h at %0t", pcOut, mPc, $time);
        end
        if (validOut !== mValid) begin
            errors++;
            $display("[TB] FAIL valid: actual=%0b required=%0b at %0t", validOut, mValid, $time);
        end
        if (faultOut !== mFault) begin
            errors++;
            $display("[TB] FAIL fault: actual=%0b required=%0b at %0t", faultOut, mFault, $time);
        end
    endtask

    task automatic drain();
        idleInputs();
        for (int i = 0; i < 10 && (mOut || mHeld); i++) step(1);
        checks++;
        if (mOut || mHeld) begin
            errors++;
            $display("[TB] FAIL drain: actual=busy required=idle");
        end
    endtask

    task automatic test_reset();
        idleInputs();
        rst = 1;
        rvalid = 0;
        rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        checks += 5;
        if (instrOut !== NOP || pcOut !== 32'h0 || validOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_out: actual=%h/%h/%0b required=%h/0/0", instrOut, pcOut, validOut, NOP);
        end
        if (imemReq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_req: actual=%0b required=1", imemReq);
        end
        if (imemAddr !== RESET_PC) begin
            errors++;
            $display("[TB] FAIL reset_addr: actual=%h required=%h", imemAddr, RESET_PC);
        end
        if (faultOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_fault: actual=%0b required=0", faultOut);
        end
        if (validOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_valid: actual=%0b required=0", validOut);
        end
        rst = 0;
        modelReset();
    endtask

    task automatic test_basic();
        idleInputs();
        gnt = 1;
        step(1);
        step(1);
        checks++;
        if (instrOut !== 32'h0050_0093 || pcOut !== 32'h0 || validOut !== 1'b1) begin
            errors++;
            $display("[TB] FAIL first_fetch: actual=%h/%h/%0b required=00500093/0/1", instrOut, pcOut, validOut);
        end
        for (int i = 0; i < 4; i++) step(1);
    endtask

    task automatic test_stall_hold();
        drain();
        redirect = 1;
        redirectPc = 32'h4;
        step(1);
        redirect = 0;
        gnt = 1;
        step(1);
        gnt = 0;
        stall = 1;
        step(1);
        step(1);
        checks++;
        if (imemReq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hold_req: actual=%0b required=0", imemReq);
        end
        stall = 0;
        step(1);
        checks++;
        if (instrOut !== 32'h00A0_0113 || pcOut !== 32'h4 || validOut !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_release: actual=%h/%h/%0b required=00a00113/4/1", instrOut, pcOut, validOut);
        end
    endtask

    task automatic test_redirect_wait();
        drain();
        gnt = 1;
        step(3);
        gnt = 0;
        redirect = 1;
        redirectPc = 32'h100;
        step(3);
        redirect = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (validOut !== 1'b0) begin
                errors++;
                $display("[TB] FAIL killed_word: actual=%0b required=0", validOut);
            end
        end
        checks++;
        if (imemAddr !== 32'h100) begin
            errors++;
            $display("[TB] FAIL redirect_addr: actual=%h required=00000100", imemAddr);
        end
        gnt = 1;
        step(1);
        gnt = 0;
    endtask

    task automatic test_flush_stall();
        drain();
        gnt = 1;
        step(1);
        gnt = 0;
        step(1);
        flush = 1;
        stall = 1;
        step(1);
        checks++;
        if (instrOut !== 32'h0000_0013 || pcOut !== 32'h0 || validOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL flush_stall: actual=%h/%h/%0b required=00000013/0/0", instrOut, pcOut, validOut);
        end
        flush = 0;
        stall = 0;
    endtask

    task automatic test_wrap_and_misalign();
        drain();
        redirect = 1;
        redirectPc = 32'hFFFF_FFFC;
        step(1);
        redirect = 0;
        gnt = 1;
        step(1);
        step(1);
        checks++;
        if (imemAddr !== 32'h0) begin
            errors++;
            $display("[TB] FAIL wrap_addr: actual=%h required=00000000", imemAddr);
        end
        step(1);
        drain();
        redirect = 1;
        redirectPc = 32'h102;
        step(1);
        redirect = 0;
        gnt = 1;
`ifdef FETCH_MISALIGN_CHECK_EN
        for (int i = 0; i < 3; i++) begin
            step(1);
            checks++;
            if (imemReq !== 1'b0 || faultOut !== 1'b1) begin
                errors++;
                $display("[TB] FAIL misalign_halt: actual=req%0b/fault%0b required=req0/fault1", imemReq, faultOut);
            end
        end
        redirect = 1;
        redirectPc = 32'h200;
        step(1);
        redirect = 0;
        checks++;
        if (imemReq !== 1'b1 || imemAddr !== 32'h200) begin
            errors++;
            $display("[TB] FAIL misalign_resume: actual=%0b/%h required=1/00000200", imemReq, imemAddr);
        end
`else
        checks++;
        if (imemAddr !== 32'h100 || faultOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lsb_force: actual=%h/%0b required=00000100/0", imemAddr, faultOut);
        end
`endif
        step(1);
        gnt = 0;
    endtask

    task automatic test_reset_inflight();
        drain();
        redirect = 1;
        redirectPc = 32'h0000_0800;
        step(1);
        redirect = 0;
        gnt = 1;
        step(3);
        gnt = 0;
        rst = 1;
        #2;
        checks++;
        if (imemReq !== 1'b1 || imemAddr !== RESET_PC || validOut !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_async: actual=%0b/%h/%0b required=1/%h/0", imemReq, imemAddr, validOut, RESET_PC);
        end
        @(posedge clk);
        #1;
        rst = 0;
        modelReset();
        strayRvalid = 1;
        step(1);
        strayRvalid = 0;
        gnt = 1;
        step(1);
        step(1);
        gnt = 0;
    endtask

    task automatic test_random();
        drain();
        for (int i = 0; i < 600; i++) begin
            gnt      = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 4) == 0);
            flush    = ($urandom_range(0, 11) == 0);
            redirect = ($urandom_range(0, 13) == 0) && !(mOut && respCnt == 1);
            case ($urandom_range(0, 3))
                0:       redirectPc = 32'hFFFF_FFF0 | ($urandom & 32'hF);
                1:       redirectPc = $urandom & 32'h0000_0FFC;
                default: redirectPc = $urandom;
            endcase
`ifdef FETCH_MISALIGN_CHECK_EN
            if ($urandom_range(0, 3) != 0) redirectPc = redirectPc & 32'hFFFF_FFFC;
`endif
            step($urandom_range(1, 3));
        end
        idleInputs();
    endtask

    initial begin
        modelReset();
        idleInputs();
        rst = 1;
        rvalid = 0;
        rdata = 32'h0;
        test_reset();
        test_basic();
        test_stall_hold();
        test_redirect_wait();
        test_flush_stall();
        test_wrap_and_misalign();
        test_reset_inflight();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
